// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_unit: splits 32-bit byte/half/word loads and stores into         |
// | big-endian byte accesses on a registered-read, byte-wide RAM port.          |
// | Optional: MAU_ALIGN_CHECK_EN rejects misaligned half/word requests.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_access_unit #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_write_i,
    input  logic [1:0]               req_size_i,
    input  logic                     req_signed_i,
    input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0]    req_wdata_i,
    output logic                     rsp_valid_o,
    output logic [DATA_WIDTH-1:0]    rsp_rdata_o,
    output logic                     rsp_error_o,
    output logic [ADDRESS_WIDTH-1:0] ram_addr_o,
    output logic [7:0]               ram_wdata_o,
    output logic                     ram_we_o,
    input  logic [7:0]               ram_rdata_i,
    input  logic                     ram_busy_i
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic                     ready_q;
    logic                     write_q, write_d;
    logic [1:0]               size_q, size_d;
    logic                     signed_q, signed_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [1:0]               k_q, k_d;
    logic [23:0]              acc_q, acc_d;
    logic                     err_q, err_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic [ADDRESS_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]               ram_wdata_q, ram_wdata_d;

    logic [1:0]               last_k;
    logic [1:0]               wr_idx;
    logic [7:0]               wr_byte;
    logic [ADDRESS_WIDTH-1:0] byte_addr;
    logic [31:0]              raw;
    logic                     misalign;
    logic                     req_err;

    assign last_k    = (size_q == 2'b00) ? 2'd0 : (size_q == 2'b01) ? 2'd1 : 2'd3;
    assign byte_addr = addr_q + ADDRESS_WIDTH'(k_q);
    // Byte 0 is the most significant byte of the right-aligned store data
    assign wr_idx    = last_k - k_q;
    assign wr_byte   = 8'(wdata_q >> {wr_idx, 3'b000});
    assign raw       = {acc_q, ram_rdata_i};

`ifdef MAU_ALIGN_CHECK_EN
    assign misalign = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                      ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif
    assign req_err = (req_size_i == 2'b11) || misalign;

    assign req_ready_o = (state_q == ST_IDLE) && ready_q;
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_error_o = (state_q == ST_RESP) && err_q;
    assign ram_we_o    = (state_q == ST_WR);
    assign rsp_rdata_o = rdata_q;
    assign ram_addr_o  = ram_addr_d;
    assign ram_wdata_o = ram_wdata_d;

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        signed_d    = signed_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        k_d         = k_q;
        acc_d       = acc_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    write_d  = req_write_i;
                    size_d   = req_size_i;
                    signed_d = req_signed_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    k_d      = 2'd0;
                    acc_d    = 24'd0;
                    err_d    = req_err;
                    if (req_err) begin
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else if (req_write_i) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD_ADDR;
                    end
                end
            end
            ST_RD_ADDR: begin
                ram_addr_d = byte_addr;
                state_d    = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                // A busy RAM returns garbage; the same byte is simply re-addressed
                if (ram_busy_i) begin
                    state_d = ST_RD_ADDR;
                end else begin
                    acc_d = raw[23:0];
                    k_d   = k_q + 2'd1;
                    if (k_q == last_k) begin
                        case (size_q)
                            2'b00:   rdata_d = {{24{signed_q & raw[7]}}, raw[7:0]};
                            2'b01:   rdata_d = {{16{signed_q & raw[15]}}, raw[15:0]};
                            default: rdata_d = raw;
                        endcase
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_RD_ADDR;
                    end
                end
            end
            ST_WR: begin
                ram_addr_d  = byte_addr;
                ram_wdata_d = wr_byte;
                k_d         = k_q + 2'd1;
                if (k_q == last_k) begin
                    rdata_d = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            k_q         <= 2'd0;
            acc_q       <= 24'd0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            ready_q     <= 1'b1;
            write_q     <= write_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_access_unit: scoreboard bench with a byte-wide registered-read RAM.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
    logic [31:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;
    logic        ram_we, ram_busy;

    mem_access_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_size_i  (req_size),
        .req_signed_i(req_signed),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_error_o (rsp_error),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_we_o    (ram_we),
        .ram_rdata_i (ram_rdata),
        .ram_busy_i  (ram_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          we;
        int          acc_cyc;
        int          we_base;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          we_total = 0;
    logic [7:0]  mem [256];
    logic        mem_clr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_mem(input int a, input logic [7:0] exp);
        check($sformatf("mem[0x%02h]", a), {24'd0, mem[a]}, {24'd0, exp});
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: synchronous write, registered read
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
        end else if (ram_we) begin
            mem[ram_addr[7:0]] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr[7:0]];
    end

    always @(negedge clk) begin
        exp_t e;
        if (ram_we) we_total++;
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
                check("rsp_latency", 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
                check("ram_we_count", 32'(we_total - e.we_base), 32'(e.we));
            end
        end
    end

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int lat, input int we, input logic busy_first);
        exp_t e;
        int   t;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        e.rdata   = exp_rd;
        e.err     = exp_err;
        e.lat     = lat;
        e.we      = we;
        e.acc_cyc = cyc + 1;
        e.we_base = we_total;
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        if (busy_first) begin
            @(negedge clk);
            ram_busy = 1'b1;
            @(negedge clk);
            ram_busy = 1'b0;
        end
        t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            check("rsp_timeout", 32'd1, 32'd0);
            sb_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; mem_clr = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; ram_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        mem_clr = 1'b0;
        reset   = 1'b0;
        #1 check("ready_before_clk", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("ready_after_clk", {31'd0, req_ready}, 32'd1);

        // Word store then load
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 5, 4, 1'b0);
        check_mem(8'h10, 8'h11); check_mem(8'h11, 8'h22);
        check_mem(8'h12, 8'h33); check_mem(8'h13, 8'h44);
        do_req(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'h11223344, 1'b0, 9, 0, 1'b0);
        @(negedge clk);
        check("rdata_held", rsp_rdata, 32'h11223344);

        // Byte store with junk upper bits, then signed/unsigned byte loads
        do_req(1'b1, 2'b00, 1'b0, 32'h20, 32'h12345680, 32'h0, 1'b0, 2, 1, 1'b0);
        check_mem(8'h20, 8'h80); check_mem(8'h21, 8'h00);
        do_req(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'hFFFFFF80, 1'b0, 3, 0, 1'b0);
        do_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'h00000080, 1'b0, 3, 0, 1'b0);

        // Half store, then half loads with and without a busy retry
        do_req(1'b1, 2'b01, 1'b0, 32'h20, 32'hDEAD80A5, 32'h0, 1'b0, 3, 2, 1'b0);
        check_mem(8'h20, 8'h80); check_mem(8'h21, 8'hA5); check_mem(8'h22, 8'h00);
        do_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'hFFFF80A5, 1'b0, 7, 0, 1'b1);
        do_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 32'h000080A5, 1'b0, 5, 0, 1'b0);

        // Reserved size
        do_req(1'b0, 2'b11, 1'b1, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0);
        do_req(1'b1, 2'b11, 1'b0, 32'h30, 32'hCAFEF00D, 32'h0, 1'b1, 1, 0, 1'b0);
        check_mem(8'h30, 8'h00);

        // Misaligned accesses
`ifdef MAU_ALIGN_CHECK_EN
        do_req(1'b1, 2'b10, 1'b0, 32'h03, 32'hDEADBEEF, 32'h0, 1'b1, 1, 0, 1'b0);
        check_mem(8'h03, 8'h00);
        do_req(1'b0, 2'b10, 1'b0, 32'h03, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0);
        do_req(1'b0, 2'b01, 1'b1, 32'h21, 32'h0, 32'h0, 1'b1, 1, 0, 1'b0);
`else
        do_req(1'b1, 2'b10, 1'b0, 32'h03, 32'hDEADBEEF, 32'h0, 1'b0, 5, 4, 1'b0);
        check_mem(8'h03, 8'hDE); check_mem(8'h04, 8'hAD);
        check_mem(8'h05, 8'hBE); check_mem(8'h06, 8'hEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h03, 32'h0, 32'hDEADBEEF, 1'b0, 9, 0, 1'b0);
        do_req(1'b0, 2'b01, 1'b1, 32'h21, 32'h0, 32'hFFFFA500, 1'b0, 5, 0, 1'b0);
`endif

        // Reset in the middle of a word store, after two bytes are written
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h40; req_wdata = 32'hAABBCCDD;
        check("abort_accept_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_ram_we", {31'd0, ram_we}, 32'd0);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        check("abort_ready_in_reset", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready_after", {31'd0, req_ready}, 32'd1);
        check_mem(8'h40, 8'hAA); check_mem(8'h41, 8'hBB); check_mem(8'h42, 8'h00);
        do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h00000011, 1'b0, 3, 0, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
